router_fsm: RTL and testbench
=============================

ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 SHALL have parameter SOFT_RST_EN, default 1, meaning 1 = per-port soft reset aborts the active packet and 0 = soft reset inputs are ignored.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 resetn  in  1  reset: synchronous, active-low.
REQ-004 pkt_valid  in  1  source packet-valid strobe.
REQ-005 data_in  in  2  destination address field (00/01/10 valid, 11 invalid); sampled only in DECODE_ADDRESS.
REQ-006 fifo_full  in  1  full flag of the currently selected output FIFO.
REQ-007 fifo_empty_0/1/2  in  1 each  empty flag of output FIFO 0/1/2.
REQ-008 soft_reset_0/1/2  in  1 each  timeout soft reset of output port 0/1/2.
REQ-009 parity_done  in  1  register block has stored the parity byte.
REQ-010 low_pkt_valid  in  1  register block saw pkt_valid fall while the FIFO was full.
REQ-011 detect_add, lfd_state, ld_state, full_state, laf_state  out  1 each  one-hot state indicators for DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL.
REQ-012 write_enb_reg  out  1  FIFO write permission to the synchroniser.
REQ-013 rst_int_reg  out  1  clears the internal parity/error registers.
REQ-014 busy  out  1  source back-pressure.

Function
REQ-015 SHALL implement an 8-state Moore FSM with states DECODE_ADDRESS (DA), LOAD_FIRST_DATA (LFD), LOAD_DATA (LD), WAIT_TILL_EMPTY (WTE), FIFO_FULL_STATE (FFS), LOAD_AFTER_FULL (LAF), LOAD_PARITY (LP), CHECK_PARITY_ERROR (CPE); every output is decoded from the registered state only.
REQ-016 SHALL latch data_in into an internal 2-bit addr register on the clock edge where state==DA and pkt_valid==1; addr is held in all other states.
REQ-017 DA: SHALL go to LFD if pkt_valid, data_in!=11 and fifo_empty_<data_in>==1; go to WTE if pkt_valid, data_in!=11 and fifo_empty_<data_in>==0; otherwise stay in DA, including address 11, which is dropped.
REQ-018 WTE: SHALL go to LFD when fifo_empty_<addr>==1; otherwise stay in WTE.
REQ-019 LFD: SHALL go to LD unconditionally after 1 cycle.
REQ-020 LD: SHALL go to FFS if fifo_full==1; else go to LP if pkt_valid==0; else stay in LD. fifo_full has priority when both conditions hold.
REQ-021 FFS: SHALL go to LAF when fifo_full==0; otherwise stay in FFS.
REQ-022 LAF: SHALL go to DA if parity_done==1; else go to LP if low_pkt_valid==1; else go to LD.
REQ-023 LP: SHALL go to CPE unconditionally after 1 cycle.
REQ-024 CPE: SHALL go to FFS if fifo_full==1; otherwise go to DA.
REQ-025 Soft reset: with SOFT_RST_EN=1 and soft_reset_<addr>==1 in any state except DA, the next state SHALL be DA, overriding REQ-018..024; soft resets of non-selected ports SHALL have no effect.
REQ-026 Output decode: write_enb_reg=1 in LD, LP and LAF only; rst_int_reg=1 in CPE only; busy=1 in LFD, WTE, FFS, LAF, LP and CPE, and busy=0 in DA and LD.
REQ-027 SHALL keep exactly one of the five state indicator outputs, or none, asserted per cycle; an illegal state encoding SHALL recover to DA on the next clock edge.

Reset
REQ-028 When resetn==0 at a clock edge, the FSM SHALL enter DA and clear addr to 00, with priority over soft reset and all transitions; reset mid-packet SHALL abort the packet.
REQ-029 In reset state the outputs SHALL be detect_add=1, all other outputs 0.

Verification
REQ-030 Normal packet: reset, fifo_empty_1=1, data_in=01 with pkt_valid for 1 cycle then 3 payload cycles, then pkt_valid=0 -> states DA,LFD,LD,LD,LD,LP,CPE,DA; write_enb_reg=1 in LD/LP only; rst_int_reg pulses 1 cycle.
REQ-031 Busy destination: data_in=10 with fifo_empty_2=0 for 5 cycles, then 1 -> WTE for 5 cycles with busy=1, then LFD, LD.
REQ-032 Full mid-packet: in LD, fifo_full=1 for 3 cycles -> FFS for 3 cycles with full_state=1 and busy=1; then LAF; with low_pkt_valid=1 -> LP.
REQ-033 Full at parity: in CPE with fifo_full=1 -> FFS; fifo_full drops with parity_done=1 -> LAF then DA.
REQ-034 Soft reset: in LD for addr=00, pulse soft_reset_1 -> no effect; pulse soft_reset_0 -> DA on the next cycle; repeat with SOFT_RST_EN=0 -> stays in LD.
REQ-035 Invalid address and reset: data_in=11 with pkt_valid -> remains in DA with busy=0; resetn=0 asserted during FFS -> DA with detect_add=1 after 1 edge.

Source files
------------

// File: rtl/router_fsm.sv
// Router control FSM: steers one packet at a time from the source into the selected output FIFO.
// Decodes the destination, waits for a free FIFO and handles back-pressure and the parity byte.
module router_fsm #(
    parameter int unsigned SOFT_RST_EN = 1
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       full_state,
    output logic       laf_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy
);

    localparam logic [2:0] DECODE_ADDRESS     = 3'd0;
    localparam logic [2:0] LOAD_FIRST_DATA    = 3'd1;
    localparam logic [2:0] LOAD_DATA          = 3'd2;
    localparam logic [2:0] WAIT_TILL_EMPTY    = 3'd3;
    localparam logic [2:0] FIFO_FULL_STATE    = 3'd4;
    localparam logic [2:0] LOAD_AFTER_FULL    = 3'd5;
    localparam logic [2:0] LOAD_PARITY        = 3'd6;
    localparam logic [2:0] CHECK_PARITY_ERROR = 3'd7;

    logic [2:0] state_q, state_d;
    logic [1:0] addr_q, addr_d;

    logic       new_addr_ok;
    logic       new_addr_empty;
    logic       sel_empty;
    logic       sel_soft_reset;
    logic       soft_abort;

    // Empty flag of the destination being decoded this cycle (address 11 reads as not valid).
    always_comb begin
        new_addr_ok    = 1'b1;
        new_addr_empty = 1'b0;
        case (data_in)
            2'b00:   new_addr_empty = fifo_empty_0;
            2'b01:   new_addr_empty = fifo_empty_1;
            2'b10:   new_addr_empty = fifo_empty_2;
            default: new_addr_ok    = 1'b0;
        endcase
    end

    // Flags of the port latched for the packet in flight.
    always_comb begin
        sel_empty      = 1'b0;
        sel_soft_reset = 1'b0;
        case (addr_q)
            2'b00: begin
                sel_empty      = fifo_empty_0;
                sel_soft_reset = soft_reset_0;
            end
            2'b01: begin
                sel_empty      = fifo_empty_1;
                sel_soft_reset = soft_reset_1;
            end
            2'b10: begin
                sel_empty      = fifo_empty_2;
                sel_soft_reset = soft_reset_2;
            end
            default: begin
                sel_empty      = 1'b0;
                sel_soft_reset = 1'b0;
            end
        endcase
    end

    assign soft_abort = (SOFT_RST_EN != 0) && sel_soft_reset && (state_q != DECODE_ADDRESS);

    always_comb begin
        addr_d = addr_q;
        if ((state_q == DECODE_ADDRESS) && pkt_valid) begin
            addr_d = data_in;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (pkt_valid && new_addr_ok) begin
                    state_d = new_addr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (sel_empty) begin
                    state_d = LOAD_FIRST_DATA;
                end
            end
            LOAD_FIRST_DATA: begin
                state_d = LOAD_DATA;
            end
            LOAD_DATA: begin
                if (fifo_full) begin
                    state_d = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    state_d = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) begin
                    state_d = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    state_d = DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    state_d = LOAD_PARITY;
                end else begin
                    state_d = LOAD_DATA;
                end
            end
            LOAD_PARITY: begin
                state_d = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
                state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: begin
                state_d = DECODE_ADDRESS;
            end
        endcase

        // A timeout on the selected port abandons the packet wherever it is.
        if (soft_abort) begin
            state_d = DECODE_ADDRESS;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Moore outputs: decoded from the registered state only.
    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        full_state    = 1'b0;
        laf_state     = 1'b0;
        write_enb_reg = 1'b0;
        rst_int_reg   = 1'b0;
        busy          = 1'b0;
        case (state_q)
            DECODE_ADDRESS: begin
                detect_add = 1'b1;
            end
            LOAD_FIRST_DATA: begin
                lfd_state = 1'b1;
                busy      = 1'b1;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
            end
            WAIT_TILL_EMPTY: begin
                busy = 1'b1;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                busy       = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            LOAD_PARITY: begin
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
            end
            default: begin
                detect_add = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: the driver queues the expected outputs of every edge and a
// monitor compares both instances (soft reset enabled and disabled) one cycle at a time.
module tb_router_fsm;

    // {detect_add, lfd_state, ld_state, full_state, laf_state, write_enb_reg, rst_int_reg, busy}
    localparam logic [7:0] S_DA  = 8'b1000_0000;
    localparam logic [7:0] S_LFD = 8'b0100_0001;
    localparam logic [7:0] S_LD  = 8'b0010_0100;
    localparam logic [7:0] S_WTE = 8'b0000_0001;
    localparam logic [7:0] S_FFS = 8'b0001_0001;
    localparam logic [7:0] S_LAF = 8'b0000_1101;
    localparam logic [7:0] S_LP  = 8'b0000_0101;
    localparam logic [7:0] S_CPE = 8'b0000_0011;

    typedef struct {
        string      name;
        logic [7:0] e1;
        logic [7:0] e2;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic       clock = 1'b0;
    logic       resetn, pkt_valid, fifo_full;
    logic [1:0] data_in;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done, low_pkt_valid;

    logic da1, lfd1, ld1, ff1, laf1, we1, ri1, bz1;
    logic da2, lfd2, ld2, ff2, laf2, we2, ri2, bz2;
    logic [7:0] act1, act2;

    assign act1 = {da1, lfd1, ld1, ff1, laf1, we1, ri1, bz1};
    assign act2 = {da2, lfd2, ld2, ff2, laf2, we2, ri2, bz2};

    always #5 clock = ~clock;

    router_fsm #(.SOFT_RST_EN(1)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(da1), .lfd_state(lfd1), .ld_state(ld1), .full_state(ff1),
        .laf_state(laf1), .write_enb_reg(we1), .rst_int_reg(ri1), .busy(bz1)
    );

    router_fsm #(.SOFT_RST_EN(0)) dut_nsr (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(da2), .lfd_state(lfd2), .ld_state(ld2), .full_state(ff2),
        .laf_state(laf2), .write_enb_reg(we2), .rst_int_reg(ri2), .busy(bz2)
    );

    // Monitor: outputs settle after each edge; one queued entry per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_checks++;
                if (act1 !== e.e1) begin
                    n_fail++;
                    $display("FAIL %s (sr_en=1): got %b expected %b", e.name, act1, e.e1);
                end
                n_checks++;
                if (act2 !== e.e2) begin
                    n_fail++;
                    $display("FAIL %s (sr_en=0): got %b expected %b", e.name, act2, e.e2);
                end
            end
        end
    end

    task automatic cyc2(input string name, input logic [7:0] e1, input logic [7:0] e2);
        sb.push_back('{name, e1, e2});
        @(posedge clock);
        #2;
    endtask

    task automatic cyc(input string name, input logic [7:0] e);
        cyc2(name, e, e);
    endtask

    initial begin
        resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'b00; fifo_full = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        parity_done = 1'b0; low_pkt_valid = 1'b0;

        cyc("reset", S_DA);
        cyc("reset_hold", S_DA);
        resetn = 1'b1;
        cyc("idle", S_DA);

        // Normal packet to port 1.
        data_in = 2'b01; pkt_valid = 1'b1;
        cyc("norm_lfd", S_LFD);
        data_in = 2'b11;
        cyc("norm_ld1", S_LD);
        cyc("norm_ld2", S_LD);
        cyc("norm_ld3", S_LD);
        pkt_valid = 1'b0;
        cyc("norm_lp", S_LP);
        cyc("norm_cpe", S_CPE);
        cyc("norm_da", S_DA);

        // Busy destination 2; a later empty port 0 must not release the latched address.
        data_in = 2'b10; fifo_empty_2 = 1'b0; pkt_valid = 1'b1;
        cyc("wte_1", S_WTE);
        data_in = 2'b00;
        for (int i = 0; i < 4; i++) cyc("wte_hold", S_WTE);
        fifo_empty_2 = 1'b1;
        cyc("wte_lfd", S_LFD);
        cyc("wte_ld", S_LD);

        // Full mid-packet, resume straight into parity.
        fifo_full = 1'b1;
        cyc("ffs_1", S_FFS);
        cyc("ffs_2", S_FFS);
        cyc("ffs_3", S_FFS);
        fifo_full = 1'b0;
        cyc("laf", S_LAF);
        low_pkt_valid = 1'b1; pkt_valid = 1'b0;
        cyc("laf_lp", S_LP);
        low_pkt_valid = 1'b0;
        cyc("laf_cpe", S_CPE);
        cyc("laf_da", S_DA);

        // Full at parity check; parity_done beats low_pkt_valid in LAF.
        data_in = 2'b00; pkt_valid = 1'b1;
        cyc("cpe_lfd", S_LFD);
        cyc("cpe_ld", S_LD);
        pkt_valid = 1'b0;
        cyc("cpe_lp", S_LP);
        cyc("cpe_cpe", S_CPE);
        fifo_full = 1'b1;
        cyc("cpe_ffs", S_FFS);
        fifo_full = 1'b0; parity_done = 1'b1; low_pkt_valid = 1'b1;
        cyc("cpe_laf", S_LAF);
        cyc("cpe_done", S_DA);
        parity_done = 1'b0; low_pkt_valid = 1'b0;

        // fifo_full wins over pkt_valid low in LD; LAF with nothing pending returns to LD.
        pkt_valid = 1'b1;
        cyc("prio_lfd", S_LFD);
        cyc("prio_ld", S_LD);
        fifo_full = 1'b1; pkt_valid = 1'b0;
        cyc("prio_ffs", S_FFS);
        fifo_full = 1'b0; pkt_valid = 1'b1;
        cyc("prio_laf", S_LAF);
        cyc("laf_ld", S_LD);
        pkt_valid = 1'b0;
        cyc("prio_lp", S_LP);
        cyc("prio_cpe", S_CPE);
        cyc("prio_da", S_DA);

        // Soft reset in LD for addr 00.
        data_in = 2'b00; pkt_valid = 1'b1;
        cyc("sr_lfd", S_LFD);
        cyc("sr_ld", S_LD);
        soft_reset_1 = 1'b1;
        cyc("sr_other_port", S_LD);
        soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
        cyc2("sr_sel_port", S_DA, S_LD);
        soft_reset_0 = 1'b0; pkt_valid = 1'b0;
        cyc2("sr_after", S_DA, S_LP);
        resetn = 1'b0;
        cyc("sr_resync", S_DA);
        resetn = 1'b1;

        // Soft reset while waiting for a busy FIFO.
        data_in = 2'b01; fifo_empty_1 = 1'b0; pkt_valid = 1'b1;
        cyc("srw_wte", S_WTE);
        pkt_valid = 1'b0; soft_reset_1 = 1'b1;
        cyc2("srw_abort", S_DA, S_WTE);
        soft_reset_1 = 1'b0; resetn = 1'b0;
        cyc("srw_resync", S_DA);
        resetn = 1'b1; fifo_empty_1 = 1'b1;

        // Invalid address is dropped.
        data_in = 2'b11; pkt_valid = 1'b1;
        cyc("inv_1", S_DA);
        cyc("inv_2", S_DA);

        // Reset during FFS, also over a pending soft reset.
        data_in = 2'b01;
        cyc("rst_lfd", S_LFD);
        cyc("rst_ld", S_LD);
        fifo_full = 1'b1;
        cyc("rst_ffs", S_FFS);
        resetn = 1'b0; soft_reset_1 = 1'b1;
        cyc("rst_in_ffs", S_DA);
        resetn = 1'b1; soft_reset_1 = 1'b0; fifo_full = 1'b0; pkt_valid = 1'b0;
        cyc("rst_idle", S_DA);

        @(posedge clock);
        #3;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
